// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and FSM state encodings
// for the slave and the master.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        M_IDLE,
        M_ADDR,
        M_DATA,
        M_RESP
    } m_state_e;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Register bank: byte-enabled synchronous write, combinational read,
// asynchronous clear.
module axi4_lite_regfile #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wen,
    input  logic [$clog2(NUM_REGS)-1:0]   widx,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH/8-1:0]       wstrb,
    input  logic [$clog2(NUM_REGS)-1:0]   ridx,
    output logic [DATA_WIDTH-1:0]         rdata
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wen) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b]) begin
                    regs[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = regs[ridx];

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite register slave: independent read and write FSMs over one
// register bank; out-of-range addresses answer SLVERR.
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic [ADDRESS_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                       S_AXI_AWVALID,
    output logic                       S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]      S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
    input  logic                       S_AXI_WVALID,
    output logic                       S_AXI_WREADY,
    output logic [1:0]                 S_AXI_BRESP,
    output logic                       S_AXI_BVALID,
    input  logic                       S_AXI_BREADY,
    input  logic [ADDRESS_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                       S_AXI_ARVALID,
    output logic                       S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                 S_AXI_RRESP,
    output logic                       S_AXI_RVALID,
    input  logic                       S_AXI_RREADY
);

    localparam int B  = $clog2(DATA_WIDTH/8);
    localparam int IW = $clog2(NUM_REGS);

    function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
        return (a >> (B + IW)) == '0;
    endfunction

    w_state_e w_state, w_next;
    r_state_e r_state, r_next;

    logic                  live;
    logic                  w_acc, r_acc;
    logic                  w_ok, r_ok;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q, rf_rdata;

    assign w_ok = in_range(S_AXI_AWADDR);
    assign r_ok = in_range(S_AXI_ARADDR);

    always_comb begin
        w_next = w_state;
        w_acc  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                w_acc = live && S_AXI_AWVALID && S_AXI_WVALID;
                if (w_acc) w_next = W_RESP;
            end
            W_RESP: begin
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
        endcase
    end

    always_comb begin
        r_next = r_state;
        r_acc  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                r_acc = live && S_AXI_ARVALID;
                if (r_acc) r_next = R_DATA;
            end
            R_DATA: begin
                if (S_AXI_RREADY) r_next = R_IDLE;
            end
        endcase
    end

    // live holds ready low during reset and for the first edge after release
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            live    <= 1'b0;
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            bresp_q <= RESP_OKAY;
            rresp_q <= RESP_OKAY;
            rdata_q <= '0;
        end else begin
            live    <= 1'b1;
            w_state <= w_next;
            r_state <= r_next;
            if (w_acc) bresp_q <= w_ok ? RESP_OKAY : RESP_SLVERR;
            if (r_acc) begin
                rresp_q <= r_ok ? RESP_OKAY : RESP_SLVERR;
                rdata_q <= r_ok ? rf_rdata : '0;
            end
        end
    end

    axi4_lite_regfile #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .wen   (w_acc && w_ok),
        .widx  (S_AXI_AWADDR[B+IW-1:B]),
        .wdata (S_AXI_WDATA),
        .wstrb (S_AXI_WSTRB),
        .ridx  (S_AXI_ARADDR[B+IW-1:B]),
        .rdata (rf_rdata)
    );

    assign S_AXI_AWREADY = w_acc;
    assign S_AXI_WREADY  = w_acc;
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = live && (r_state == R_IDLE);
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

endmodule
